// File: rtl/dsp_fetch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// Module : dsp_fetch_sequencer_pkg
// Brief  : Shared definitions for the DSP fetch sequencer.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dsp_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,
        FS_FETCH   = 2'd1,
        FS_DISCARD = 2'd2,
        FS_HALT    = 2'd3
    } fetch_state_e;

    localparam logic [15:0] RESET_VEC_DEFAULT = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/dsp_instr_buf.sv
// ---------------------------------------------------------------------------
// Module : dsp_instr_buf
// Brief  : One-entry valid/ready instruction register with synchronous clear.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dsp_instr_buf #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic [INSTR_W-1:0] data_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] data_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;

    // Clear beats load: a redirect discards the word arriving in the same cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            pc_d    = pc_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;

endmodule

`default_nettype wire

// File: rtl/dsp_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// Module : dsp_fetch_sequencer
// Brief  : PC sequencer and instruction-fetch controller with redirect/halt.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dsp_fetch_sequencer
    import dsp_fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                INSTR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               jump_flag,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic               flush,
    input  logic               halt_req,
    input  logic               run,
    output logic               halted
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              halt_pend_q, halt_pend_d;
    logic              flush_q, flush_d;
    logic              boot_q;

    logic start;
    logic buf_load;
    logic buf_clear;
    logic halt_now;
    logic buf_free;
    logic redirect;

    assign halt_now = halt_req | halt_pend_q;
    assign buf_free = ~instr_valid | instr_ready;
    assign redirect = jump_flag & (state_q != FS_IDLE);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        busy_d      = busy_q;
        halt_pend_d = halt_pend_q;
        flush_d     = 1'b0;
        start       = 1'b0;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;

        case (state_q)
            FS_IDLE: begin
                // boot_q stretches IDLE to one full cycle after reset release.
                if (boot_q) state_d = FS_FETCH;
            end
            FS_FETCH: begin
                start = ~busy_q & ~jump_flag & ~halt_now & buf_free;
                if (start) addr_d = pc_q;
                if (busy_q || start) begin
                    if (imem_ack) begin
                        busy_d  = 1'b0;
                        state_d = halt_now ? FS_HALT : FS_FETCH;
                        if (!jump_flag) begin
                            buf_load = 1'b1;
                            pc_d     = pc_q + 1'b1;
                        end
                    end else begin
                        busy_d      = 1'b1;
                        halt_pend_d = halt_now;
                        if (jump_flag) state_d = FS_DISCARD;
                    end
                end else if (halt_now) begin
                    state_d = FS_HALT;
                end
            end
            FS_DISCARD: begin
                if (imem_ack) begin
                    busy_d  = 1'b0;
                    state_d = halt_now ? FS_HALT : FS_FETCH;
                end else begin
                    halt_pend_d = halt_now;
                end
            end
            FS_HALT: begin
                if (run && !halt_req) state_d = FS_FETCH;
            end
            default: state_d = FS_IDLE;
        endcase

        if (state_d == FS_HALT) halt_pend_d = 1'b0;

        if (redirect) begin
            pc_d      = jump_addr;
            buf_clear = 1'b1;
            flush_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FS_IDLE;
            pc_q        <= RESET_VEC;
            addr_q      <= RESET_VEC;
            busy_q      <= 1'b0;
            halt_pend_q <= 1'b0;
            flush_q     <= 1'b0;
            boot_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            halt_pend_q <= halt_pend_d;
            flush_q     <= flush_d;
            boot_q      <= 1'b1;
        end
    end

    // While a request is in flight the latched address is presented, so
    // a redirect can move pc without disturbing the handshake.
    assign imem_req  = busy_q | start;
    assign imem_addr = busy_q ? addr_q : pc_q;
    assign flush     = flush_q;
    assign halted    = (state_q == FS_HALT);

    dsp_instr_buf #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(buf_clear),
        .load_i (buf_load),
        .data_i (imem_data),
        .pc_i   (imem_addr),
        .ready_i(instr_ready),
        .valid_o(instr_valid),
        .data_o (instr),
        .pc_o   (instr_pc)
    );

endmodule

`default_nettype wire
